// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared scoreboard types and default sizing for the decode-stage hazard scoreboard.
package reg_hazard_scoreboard_pkg;

    localparam int SB_DEF_NUM_REGS    = 32;
    localparam int SB_DEF_ADDR_W      = 5;
    localparam int SB_DEF_CNT_W       = 2;
    localparam int SB_DEF_WB_BYPASS   = 1;
    localparam int SB_DEF_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_STALL = 2'd1,
        SB_FLUSH = 2'd2
    } sb_state_e;

endpackage

// File: rtl/reg_hazard_scoreboard_pending_counter.sv
// Per-register count of writes in flight; saturating up/down with a clear that beats both.
module reg_hazard_scoreboard_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic at_max,
    output logic is_one
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign nonzero = (cnt_q != '0);
    assign at_max  = &cnt_q;
    assign is_one  = (cnt_q == CNT_W'(1));

    // inc and dec together leave the count unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage RAW/overflow hazard scoreboard with flush handling and stall statistics.
//   state    | meaning
//   SB_RUN   | decode issuing normally
//   SB_STALL | decode held on a RAW or pending-overflow hazard
//   SB_FLUSH | one-cycle squash: counters cleared, WB ignored, decode held
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = SB_DEF_NUM_REGS,
    parameter int ADDR_W      = SB_DEF_ADDR_W,
    parameter int CNT_W       = SB_DEF_CNT_W,
    parameter int WB_BYPASS   = SB_DEF_WB_BYPASS,
    parameter int STALL_CNT_W = SB_DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [ADDR_W-1:0]      id_rs,
    input  logic [ADDR_W-1:0]      id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_reg_write,
    input  logic [ADDR_W-1:0]      id_dest,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_dest,
    input  logic                   flush,
    output logic                   id_stall,
    output logic                   id_issue,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   sb_error
);

    sb_state_e               state_q, state_d;
    logic [STALL_CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic                    sb_error_q, sb_error_d;
    logic [NUM_REGS-1:0]     nz_vec, one_vec, max_vec, busy_eff;
    logic                    hazard, ovf, in_flush, clr_all, wb_act;

    assign nz_vec[0]  = 1'b0;
    assign one_vec[0] = 1'b0;
    assign max_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc, dec;
        assign inc = id_issue & id_reg_write & (id_dest == ADDR_W'(r));
        assign dec = wb_act & (wb_dest == ADDR_W'(r)) & nz_vec[r];
        reg_hazard_scoreboard_pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr_all),
            .inc     (inc),
            .dec     (dec),
            .nonzero (nz_vec[r]),
            .at_max  (max_vec[r]),
            .is_one  (one_vec[r])
        );
    end

    // a retire of the last outstanding write is visible to decode in the same cycle
    always_comb begin
        busy_eff = nz_vec;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (WB_BYPASS != 0 && wb_valid && wb_dest == ADDR_W'(r) && one_vec[r]) begin
                busy_eff[r] = 1'b0;
            end
        end
    end

    always_comb begin
        in_flush = (state_q == SB_FLUSH);
        clr_all  = flush | in_flush;
        wb_act   = wb_valid & !clr_all & (wb_dest != '0);
        ovf      = id_reg_write & (id_dest != '0) & max_vec[id_dest]
                   & !(wb_valid & (wb_dest == id_dest));
        hazard   = id_valid & ((id_uses_rs & busy_eff[id_rs])
                               | (id_uses_rt & busy_eff[id_rt]) | ovf);
        id_issue = !reset & id_valid & !hazard & !in_flush & !flush;
        id_stall = reset | (id_valid & !id_issue) | in_flush | flush;

        sb_error_d = sb_error_q | (wb_act & !nz_vec[wb_dest]);

        stall_cycles_d = stall_cycles_q;
        if (id_stall && id_valid && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end

        state_d = state_q;
        case (state_q)
            SB_RUN:   state_d = flush ? SB_FLUSH : (hazard ? SB_STALL : SB_RUN);
            SB_STALL: state_d = flush ? SB_FLUSH : (hazard ? SB_STALL : SB_RUN);
            SB_FLUSH: state_d = flush ? SB_FLUSH : SB_RUN;
            default:  state_d = SB_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SB_RUN;
            stall_cycles_q <= '0;
            sb_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            sb_error_q     <= sb_error_d;
        end
    end

    assign busy_vec     = nz_vec;
    assign stall_cycles = stall_cycles_q;
    assign sb_error     = sb_error_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic against a per-register pending-count model.
module tb_reg_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_uses_rs, id_uses_rt, id_reg_write, wb_valid, flush;
    logic [4:0]  id_rs, id_rt, id_dest, wb_dest;
    logic        id_stall, id_issue, sb_error;
    logic [31:0] busy_vec;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    reg_hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_write (id_reg_write),
        .id_dest      (id_dest),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .flush        (flush),
        .id_stall     (id_stall),
        .id_issue     (id_issue),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles),
        .sb_error     (sb_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int pend[32];
    bit m_err;
    int m_stall;
    bit m_inflush;
    bit obs_stall, obs_issue;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit busy_seen(input int r);
        if (r == 0 || pend[r] == 0) return 1'b0;
        if (wb_valid && int'(wb_dest) == r && pend[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit wr, input int dest, input bit wbv, input int wbd, input bit fl);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_reg_write = wr; id_dest = 5'(dest); wb_valid = wbv; wb_dest = 5'(wbd); flush = fl;
    endtask

    task automatic run_cycle();
        bit haz, ovf, e_stall, e_issue;
        logic [31:0] bv;
        int d, w;
        @(negedge clk);
        d = int'(id_dest);
        w = int'(wb_dest);
        if (reset) begin
            e_stall = 1'b1;
            e_issue = 1'b0;
        end else begin
            ovf = id_reg_write && d != 0 && pend[d] == 3 && !(wb_valid && w == d);
            haz = id_valid && ((id_uses_rs && busy_seen(int'(id_rs)))
                               || (id_uses_rt && busy_seen(int'(id_rt))) || ovf);
            e_issue = id_valid && !haz && !m_inflush && !flush;
            e_stall = (id_valid && !e_issue) || m_inflush || flush;
        end
        obs_stall = id_stall;
        obs_issue = id_issue;
        check_val("id_stall", id_stall, e_stall);
        check_val("id_issue", id_issue, e_issue);

        if (reset) begin
            foreach (pend[r]) pend[r] = 0;
            m_err = 0; m_stall = 0; m_inflush = 0;
        end else begin
            if (e_stall && id_valid && m_stall < 65535) m_stall++;
            if (flush || m_inflush) begin
                foreach (pend[r]) pend[r] = 0;
                m_inflush = flush;
            end else begin
                bit do_dec = 0;
                if (wb_valid && w != 0) begin
                    if (pend[w] == 0) m_err = 1;
                    else do_dec = 1;
                end
                if (e_issue && id_reg_write && d != 0) pend[d]++;
                if (do_dec) pend[w]--;
            end
        end

        @(posedge clk);
        #1;
        bv = '0;
        for (int r = 0; r < 32; r++) if (pend[r] > 0) bv[r] = 1'b1;
        check_val("busy_vec", busy_vec, bv);
        check_val("stall_cycles", stall_cycles, 32'(m_stall));
        check_val("sb_error", sb_error, 32'(m_err));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        run_cycle();
        check_val("rst_busy", busy_vec, 0);
        reset = 1'b0;

        // RAW on $3, released by a bypassed writeback
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0); run_cycle();
        drive(1, 3, 4, 1, 1, 0, 0, 0, 0, 0); run_cycle();
        check_val("t1_stall", obs_stall, 1);
        check_val("t1_busy3", busy_vec[3], 1);
        drive(1, 3, 4, 1, 1, 0, 0, 1, 3, 0); run_cycle();
        check_val("t1_issue", obs_issue, 1);
        check_val("t1_busy3_clr", busy_vec[3], 0);

        // $0 never busy
        repeat (3) begin
            drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0); run_cycle();
            check_val("t2_stall", obs_stall, 0);
            check_val("t2_busy0", busy_vec[0], 0);
        end

        // pending-count overflow on $5
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); run_cycle();
            check_val("t3_issue", obs_issue, 1);
        end
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); run_cycle();
        check_val("t3_ovf_stall", obs_stall, 1);
        drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0); run_cycle();
        check_val("t3_ovf_issue", obs_issue, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); run_cycle();
        check_val("t3_busy5", busy_vec[5], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); run_cycle();
        check_val("t3_busy5_clr", busy_vec[5], 0);

        // simultaneous issue and retire on $7
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); run_cycle();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0); run_cycle();
        check_val("t4_busy7", busy_vec[7], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); run_cycle();
        check_val("t4_busy7_clr", busy_vec[7], 0);
        check_val("t4_err", sb_error, 0);

        // flush from STALL, then a stale writeback
        drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); run_cycle();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); run_cycle();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); run_cycle();
        drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); run_cycle();
        drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 1); run_cycle();
        check_val("t5_busy_clr", busy_vec, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0); run_cycle();
        check_val("t5_flush_stall", obs_stall, 1);
        check_val("t5_err_ignored", sb_error, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
        check_val("t5_run", obs_stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0); run_cycle();
        check_val("t5_err", sb_error, 1);

        reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle(); reset = 1'b0;

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bit wbv = 0;
            int wbd = 0;
            if ($urandom_range(0, 2) == 0) begin
                int s = $urandom_range(1, 7);
                for (int k = 0; k < 7; k++) begin
                    int r = 1 + (s + k) % 7;
                    if (!wbv && pend[r] > 0) begin wbv = 1; wbd = r; end
                end
            end
            if ($urandom_range(0, 149) == 0) begin wbv = 1; wbd = $urandom_range(0, 7); end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                  wbv, wbd, $urandom_range(0, 49) == 0);
            reset = (i % 700 == 699);
            run_cycle();
        end
        reset = 1'b0;

        // long-held hazard saturates the stall counter
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); run_cycle();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (70000) run_cycle();
        check_val("t6_sat", stall_cycles, 16'hFFFF);

        reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle(); reset = 1'b0;
        check_val("t6_rst_cnt", stall_cycles, 0);
        check_val("t6_rst_busy", busy_vec, 0);
        check_val("t6_rst_err", sb_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
